// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared ISA constants (opcodes, ALU ops, exception codes) and
//               writeback result-buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // mul/div retire through the md port, never through the pipeline write
    function automatic logic is_md_op(input logic [4:0] op, input logic [4:0] alu_op);
        return (op == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_md_buffer.sv
// ============================================================================
// Module      : wb_md_buffer
// Description : One-entry mult/div result buffer; yields the regfile port to
//               the pipeline and drains when the pipeline is not writing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_md_buffer
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int EXC_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              md_valid,
    input  logic [DATA_W-1:0] md_result,
    input  logic [REG_W-1:0]  md_rd,
    input  logic              md_exc,
    input  logic              md_is_div,
    input  logic              pipe_wr,
    output logic              md_ack,
    output logic              md_wr,
    output logic [REG_W-1:0]  md_wr_reg,
    output logic [DATA_W-1:0] md_wr_data,
    output logic              buf_full
);

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic [REG_W-1:0]  r_reg;
    logic [DATA_W-1:0] r_data;
    logic [REG_W-1:0]  w_in_reg;
    logic [DATA_W-1:0] w_in_data;
    logic              w_capture;

    // exception code is folded in before capture so the buffer holds a final write
    assign w_in_reg  = md_exc ? REG_W'(EXC_REG) : md_rd;
    assign w_in_data = md_exc ? (md_is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL)) : md_result;
    assign buf_full  = (r_state == BUF_FULL);

    always_comb begin
        w_state_nxt = r_state;
        md_ack      = 1'b0;
        md_wr       = 1'b0;
        md_wr_reg   = w_in_reg;
        md_wr_data  = w_in_data;
        w_capture   = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (md_valid && !reset) begin
                    md_ack = 1'b1;
                    if (pipe_wr) begin
                        w_capture   = 1'b1;
                        w_state_nxt = BUF_FULL;
                    end else begin
                        md_wr = 1'b1;
                    end
                end
            end
            BUF_FULL: begin
                md_wr_reg  = r_reg;
                md_wr_data = r_data;
                if (!pipe_wr && !reset) begin
                    md_wr       = 1'b1;
                    w_state_nxt = BUF_EMPTY;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
            r_reg   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_reg  <= w_in_reg;
                r_data <= w_in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mw_writeback_stage.sv
// ============================================================================
// Module      : mw_writeback_stage
// Description : MEM/WB pipeline register, writeback data select and regfile
//               port arbitration against the mult/div unit.
//               Optional MW_FWD_EN adds port-write and buffer bypass outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mw_writeback_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int EXC_REG  = 30,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              xm_valid,
    input  logic [31:0]       xm_insn,
    input  logic [DATA_W-1:0] xm_alu_out,
    input  logic [DATA_W-1:0] xm_mem_q,
    input  logic [DATA_W-1:0] xm_pc_plus1,
    input  logic              xm_ovf,
    input  logic              md_valid,
    input  logic [DATA_W-1:0] md_result,
    input  logic [REG_W-1:0]  md_rd,
    input  logic              md_exc,
    input  logic              md_is_div,
    output logic              md_ack,
    output logic              mw_valid,
    output logic [31:0]       mw_insn,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              md_buf_full
`ifdef MW_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              buf_fwd_valid,
    output logic [REG_W-1:0]  buf_fwd_reg,
    output logic [DATA_W-1:0] buf_fwd_data
`endif
);

    logic              r_valid;
    logic [31:0]       r_insn;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_mem_q;
    logic [DATA_W-1:0] r_pc_plus1;
    logic              r_ovf;

    logic [4:0]        w_op;
    logic [4:0]        w_alu_op;
    logic [REG_W-1:0]  w_rd;
    logic              w_dec_wr;
    logic [REG_W-1:0]  w_dec_reg;
    logic [DATA_W-1:0] w_dec_data;
    logic              w_pipe_wr;
    logic              w_md_wr;
    logic [REG_W-1:0]  w_md_reg;
    logic [DATA_W-1:0] w_md_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_insn     <= '0;
            r_alu_out  <= '0;
            r_mem_q    <= '0;
            r_pc_plus1 <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid    <= xm_valid;
            r_insn     <= xm_insn;
            r_alu_out  <= xm_alu_out;
            r_mem_q    <= xm_mem_q;
            r_pc_plus1 <= xm_pc_plus1;
            r_ovf      <= xm_ovf;
        end
    end

    assign w_op     = r_insn[31:27];
    assign w_alu_op = r_insn[6:2];
    assign w_rd     = REG_W'(r_insn[26:22]);

    always_comb begin
        w_dec_wr   = 1'b0;
        w_dec_reg  = '0;
        w_dec_data = '0;
        case (w_op)
            OP_RTYPE: begin
                if (r_ovf && (w_alu_op == ALU_ADD)) begin
                    w_dec_wr   = 1'b1;
                    w_dec_reg  = REG_W'(EXC_REG);
                    w_dec_data = DATA_W'(EXC_ADD);
                end else if (r_ovf && (w_alu_op == ALU_SUB)) begin
                    w_dec_wr   = 1'b1;
                    w_dec_reg  = REG_W'(EXC_REG);
                    w_dec_data = DATA_W'(EXC_SUB);
                end else if (!is_md_op(w_op, w_alu_op)) begin
                    w_dec_wr   = (w_rd != '0);
                    w_dec_reg  = w_rd;
                    w_dec_data = r_alu_out;
                end
            end
            OP_ADDI: begin
                if (r_ovf) begin
                    w_dec_wr   = 1'b1;
                    w_dec_reg  = REG_W'(EXC_REG);
                    w_dec_data = DATA_W'(EXC_ADDI);
                end else begin
                    w_dec_wr   = (w_rd != '0);
                    w_dec_reg  = w_rd;
                    w_dec_data = r_alu_out;
                end
            end
            OP_LW: begin
                w_dec_wr   = (w_rd != '0);
                w_dec_reg  = w_rd;
                w_dec_data = r_mem_q;
            end
            OP_JAL: begin
                w_dec_wr   = 1'b1;
                w_dec_reg  = REG_W'(LINK_REG);
                w_dec_data = r_pc_plus1;
            end
            OP_SETX: begin
                w_dec_wr   = 1'b1;
                w_dec_reg  = REG_W'(EXC_REG);
                w_dec_data = DATA_W'(r_insn[26:0]);
            end
            OP_SW, OP_BNE, OP_BLT, OP_J, OP_JR, OP_BEX: w_dec_wr = 1'b0;
            default: w_dec_wr = 1'b0;
        endcase
    end

    assign w_pipe_wr = r_valid & w_dec_wr;

    wb_md_buffer #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .EXC_REG (EXC_REG)
    ) u_md_buffer (
        .clock      (clock),
        .reset      (reset),
        .md_valid   (md_valid),
        .md_result  (md_result),
        .md_rd      (md_rd),
        .md_exc     (md_exc),
        .md_is_div  (md_is_div),
        .pipe_wr    (w_pipe_wr),
        .md_ack     (md_ack),
        .md_wr      (w_md_wr),
        .md_wr_reg  (w_md_reg),
        .md_wr_data (w_md_data),
        .buf_full   (md_buf_full)
    );

    // pipeline owns the port; an md result targeting r0 is consumed silently
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (w_pipe_wr) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = w_dec_reg;
            data_writeReg    = w_dec_data;
        end else if (w_md_wr && (w_md_reg != '0)) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = w_md_reg;
            data_writeReg    = w_md_data;
        end
    end

    assign mw_valid = r_valid;
    assign mw_insn  = r_insn;

`ifdef MW_FWD_EN
    assign fwd_valid     = ctrl_writeEnable;
    assign fwd_reg       = ctrl_writeReg;
    assign fwd_data      = data_writeReg;
    // while full the buffer is the md source, so its contents appear on w_md_*
    assign buf_fwd_valid = md_buf_full && (w_md_reg != '0);
    assign buf_fwd_reg   = w_md_reg;
    assign buf_fwd_data  = w_md_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mw_writeback_stage.sv
// ============================================================================
// Module      : tb_mw_writeback_stage
// Description : Self-checking bench: directed vector table, buffer corner
//               sequences, and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mw_writeback_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        xm_valid;
    logic [31:0] xm_insn, xm_alu_out, xm_mem_q, xm_pc_plus1;
    logic        xm_ovf;
    logic        md_valid;
    logic [31:0] md_result;
    logic [4:0]  md_rd;
    logic        md_exc, md_is_div;
    logic        md_ack, mw_valid, ctrl_writeEnable, md_buf_full;
    logic [31:0] mw_insn, data_writeReg;
    logic [4:0]  ctrl_writeReg;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mw_writeback_stage dut (
        .clock            (clock),
        .reset            (reset),
        .xm_valid         (xm_valid),
        .xm_insn          (xm_insn),
        .xm_alu_out       (xm_alu_out),
        .xm_mem_q         (xm_mem_q),
        .xm_pc_plus1      (xm_pc_plus1),
        .xm_ovf           (xm_ovf),
        .md_valid         (md_valid),
        .md_result        (md_result),
        .md_rd            (md_rd),
        .md_exc           (md_exc),
        .md_is_div        (md_is_div),
        .md_ack           (md_ack),
        .mw_valid         (mw_valid),
        .mw_insn          (mw_insn),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .md_buf_full      (md_buf_full)
    );

    typedef struct {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic        ovf;
        logic        we;
        logic [4:0]  rg;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_port(input string tag, input logic ack, input logic full,
                               input logic we, input logic [4:0] rg, input logic [31:0] d);
        chk({tag, ".md_ack"}, md_ack, ack);
        chk({tag, ".buf_full"}, md_buf_full, full);
        chk({tag, ".we"}, ctrl_writeEnable, we);
        if (we) begin
            chk({tag, ".reg"}, ctrl_writeReg, rg);
            chk({tag, ".data"}, data_writeReg, d);
        end
    endtask

    task automatic set_xm(input logic v, input logic [31:0] insn, input logic [31:0] alu);
        xm_valid = v; xm_insn = insn; xm_alu_out = alu;
        xm_mem_q = 32'h0; xm_pc_plus1 = 32'h0; xm_ovf = 1'b0;
    endtask

    task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] res,
                          input logic exc, input logic dv);
        md_valid = v; md_rd = rd; md_result = res; md_exc = exc; md_is_div = dv;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] fn);
        return {5'd0, rd, 5'd1, 5'd2, 5'd0, fn, 2'b00};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return {5'd5, rd, 5'd0, 17'd0};
    endfunction

    // Reference: which register an instruction retires into, straight from the ISA rules
    function automatic void ref_pipe(input logic [31:0] insn, input logic [31:0] alu,
                                     input logic [31:0] mem, input logic [31:0] pc,
                                     input logic ovf, output logic we,
                                     output logic [4:0] rg, output logic [31:0] d);
        int op, rd, fn;
        op = int'(insn[31:27]); rd = int'(insn[26:22]); fn = int'(insn[6:2]);
        we = 1'b0; rg = 5'd0; d = 32'd0;
        if (op == 3) begin
            we = 1'b1; rg = 5'd31; d = pc;
        end else if (op == 21) begin
            we = 1'b1; rg = 5'd30; d = {5'd0, insn[26:0]};
        end else if (op == 5 && ovf) begin
            we = 1'b1; rg = 5'd30; d = 32'd2;
        end else if (op == 0 && ovf && fn == 0) begin
            we = 1'b1; rg = 5'd30; d = 32'd1;
        end else if (op == 0 && ovf && fn == 1) begin
            we = 1'b1; rg = 5'd30; d = 32'd3;
        end else if (((op == 0 && fn != 6 && fn != 7) || op == 5) && rd != 0) begin
            we = 1'b1; rg = insn[26:22]; d = alu;
        end else if (op == 8 && rd != 0) begin
            we = 1'b1; rg = insn[26:22]; d = mem;
        end
    endfunction

    logic [36:0] q[$];
    logic        m_valid, m_ovf, m_ack;
    logic [31:0] m_insn, m_alu, m_mem, m_pc;
    logic [4:0]  ops[12];
    logic [4:0]  fns[6];

    initial begin
        vecs[0]  = '{1'b1, addi(5'd3) | 32'd7, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'd7};
        vecs[1]  = '{1'b1, rtype(5'd4, 5'd1), 32'h9, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd3};
        vecs[2]  = '{1'b1, rtype(5'd4, 5'd0), 32'h9, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd1};
        vecs[3]  = '{1'b1, addi(5'd6), 32'h9, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd2};
        vecs[4]  = '{1'b1, {5'd3, 27'd100}, 32'h1, 32'd0, 32'h40, 1'b0, 1'b1, 5'd31, 32'h40};
        vecs[5]  = '{1'b1, {5'd21, 27'h123}, 32'h1, 32'd0, 32'd0, 1'b0, 1'b1, 5'd30, 32'h123};
        vecs[6]  = '{1'b1, {5'd7, 5'd3, 5'd2, 17'd4}, 32'h6, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[7]  = '{1'b1, rtype(5'd0, 5'd0), 32'h6, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[8]  = '{1'b1, {5'd8, 5'd9, 5'd1, 17'd0}, 32'h6, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, rtype(5'd6, 5'd6), 32'h6, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[10] = '{1'b1, rtype(5'd7, 5'd2), 32'h55, 32'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h55};
        vecs[11] = '{1'b1, addi(5'd0), 32'h3, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd2};
        vecs[12] = '{1'b0, addi(5'd3), 32'h7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};
        ops = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 5'd8, 5'd3, 5'd21, 5'd7, 5'd2, 5'd4, 5'd22};
        fns = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7};

        reset = 1'b1;
        set_xm(1'b0, 32'h0, 32'h0);
        set_md(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        expect_port("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("reset.reg", ctrl_writeReg, 32'd0);
        chk("reset.data", data_writeReg, 32'd0);
        chk("reset.mw_valid", mw_valid, 32'd0);
        chk("reset.mw_insn", mw_insn, 32'd0);

        // Directed single-instruction vectors
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            xm_valid = vecs[i].valid; xm_insn = vecs[i].insn; xm_alu_out = vecs[i].alu;
            xm_mem_q = vecs[i].mem; xm_pc_plus1 = vecs[i].pc; xm_ovf = vecs[i].ovf;
            @(negedge clock);
            set_xm(1'b0, 32'h0, 32'h0);
            #1;
            expect_port($sformatf("vec%0d", i), 1'b0, 1'b0, vecs[i].we, vecs[i].rg, vecs[i].d);
        end

        // Capture while add $2 writes, then drain
        @(negedge clock); set_xm(1'b1, rtype(5'd2, 5'd0), 32'd11);
        @(negedge clock); set_xm(1'b0, 32'h0, 32'h0); set_md(1'b1, 5'd5, 32'd42, 1'b0, 1'b0);
        #1; expect_port("cap", 1'b1, 1'b0, 1'b1, 5'd2, 32'd11);
        @(negedge clock); set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #1; expect_port("drain", 1'b0, 1'b1, 1'b1, 5'd5, 32'd42);
        @(negedge clock);
        #1; expect_port("idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Second result held off while FULL under back-to-back writers
        @(negedge clock); set_xm(1'b1, addi(5'd1), 32'd1);
        @(negedge clock); set_xm(1'b1, addi(5'd2), 32'd2); set_md(1'b1, 5'd5, 32'd42, 1'b0, 1'b0);
        #1; expect_port("b2b.A", 1'b1, 1'b0, 1'b1, 5'd1, 32'd1);
        @(negedge clock); set_xm(1'b1, addi(5'd3), 32'd3); set_md(1'b1, 5'd6, 32'd77, 1'b0, 1'b0);
        #1; expect_port("b2b.B", 1'b0, 1'b1, 1'b1, 5'd2, 32'd2);
        @(negedge clock); set_xm(1'b0, 32'h0, 32'h0);
        #1; expect_port("b2b.C", 1'b0, 1'b1, 1'b1, 5'd3, 32'd3);
        @(negedge clock);
        #1; expect_port("b2b.D", 1'b0, 1'b1, 1'b1, 5'd5, 32'd42);
        @(negedge clock);
        #1; expect_port("b2b.E", 1'b1, 1'b0, 1'b1, 5'd6, 32'd77);
        @(negedge clock); set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #1; expect_port("b2b.F", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Reset discards a buffered result
        @(negedge clock); set_xm(1'b1, addi(5'd1), 32'd1);
        @(negedge clock); set_xm(1'b0, 32'h0, 32'h0); set_md(1'b1, 5'd7, 32'd99, 1'b0, 1'b0);
        #1; expect_port("rst.cap", 1'b1, 1'b0, 1'b1, 5'd1, 32'd1);
        @(negedge clock); reset = 1'b1; set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        #1; chk("rst.during.md_ack", md_ack, 32'd0);
        @(negedge clock); reset = 1'b0;
        #1; expect_port("rst.after", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("rst.after.reg", ctrl_writeReg, 32'd0);
        chk("rst.after.data", data_writeReg, 32'd0);
        chk("rst.after.mw_valid", mw_valid, 32'd0);
        chk("rst.after.mw_insn", mw_insn, 32'd0);
        @(negedge clock);
        #1; expect_port("rst.later", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // md exceptions and an r0 md destination, written directly
        @(negedge clock); set_md(1'b1, 5'd9, 32'd123, 1'b1, 1'b1);
        #1; expect_port("exc.div", 1'b1, 1'b0, 1'b1, 5'd30, 32'd5);
        @(negedge clock); set_md(1'b1, 5'd4, 32'd123, 1'b1, 1'b0);
        #1; expect_port("exc.mul", 1'b1, 1'b0, 1'b1, 5'd30, 32'd4);
        @(negedge clock); set_md(1'b1, 5'd0, 32'd5, 1'b0, 1'b0);
        #1; expect_port("md.r0", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clock); set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_valid = 1'b0; m_insn = '0; m_alu = '0; m_mem = '0; m_pc = '0; m_ovf = 1'b0; m_ack = 1'b0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic        pwe, mwe, ewe, e_ack, e_full;
            logic [4:0]  prg, erg;
            logic [31:0] pd, ed, insn;
            logic [36:0] ment;
            @(negedge clock);
            reset    = (c % 600 == 599);
            xm_valid = ($urandom_range(0, 7) != 0);
            insn     = {ops[$urandom_range(0, 11)], 27'($urandom)};
            if (insn[31:27] == 5'd0) insn[6:2] = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) insn[26:22] = 5'd0;
            xm_insn     = insn;
            xm_alu_out  = $urandom;
            xm_mem_q    = $urandom;
            xm_pc_plus1 = $urandom;
            xm_ovf      = ($urandom_range(0, 3) == 0);
            if (reset || !md_valid || m_ack) begin
                md_valid  = !reset && ($urandom_range(0, 2) == 0);
                md_rd     = 5'($urandom_range(0, 31));
                md_result = $urandom;
                md_exc    = ($urandom_range(0, 7) == 0);
                md_is_div = 1'($urandom_range(0, 1));
            end
            #1;
            ref_pipe(m_insn, m_alu, m_mem, m_pc, m_ovf, pwe, prg, pd);
            pwe    = pwe & m_valid;
            e_full = (q.size() != 0);
            e_ack  = 1'b0;
            mwe    = 1'b0;
            ment   = '0;
            if (!reset) begin
                if (q.size() != 0) begin
                    if (!pwe) begin
                        mwe  = 1'b1;
                        ment = q.pop_front();
                    end
                end else if (md_valid) begin
                    e_ack = 1'b1;
                    ment  = md_exc ? {5'd30, (md_is_div ? 32'd5 : 32'd4)} : {md_rd, md_result};
                    if (pwe) q.push_back(ment);
                    else mwe = 1'b1;
                end
            end
            ewe = pwe | (mwe & (ment[36:32] != 5'd0));
            erg = pwe ? prg : ment[36:32];
            ed  = pwe ? pd : ment[31:0];
            chk("rnd.md_ack", md_ack, e_ack);
            if (!reset) begin
                chk("rnd.buf_full", md_buf_full, e_full);
                chk("rnd.mw_valid", mw_valid, m_valid);
                chk("rnd.mw_insn", mw_insn, m_insn);
                chk("rnd.we", ctrl_writeEnable, ewe);
                if (ewe) begin
                    chk("rnd.reg", ctrl_writeReg, erg);
                    chk("rnd.data", data_writeReg, ed);
                end
            end
            m_ack = e_ack;
            if (reset) begin
                m_valid = 1'b0; m_insn = '0; m_alu = '0; m_mem = '0; m_pc = '0; m_ovf = 1'b0;
                q.delete();
            end else begin
                m_valid = xm_valid; m_insn = xm_insn; m_alu = xm_alu_out;
                m_mem = xm_mem_q; m_pc = xm_pc_plus1; m_ovf = xm_ovf;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
